// File: rtl/sram_stream_reader.sv
// sram_stream_reader: streams len SRAM words from base_addr out through a ready/valid FIFO.
// Optional stall counter enabled by defining SRAM_STREAM_READER_PERF_EN.
module sram_stream_reader #(
  parameter int NumWords  = 1024,
  parameter int DataWidth = 128,
  parameter int Latency   = 1,
  parameter int FifoDepth = 4,
  localparam int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int BeWidth   = (DataWidth + 7) / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [15:0]          len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 req_o,
  output logic                 we_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic [DataWidth-1:0] wdata_o,
  output logic [BeWidth-1:0]   be_o,
  input  logic [DataWidth-1:0] rdata_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 last_o,
  output logic [31:0]          stall_cycles_o
);
  localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntW = $clog2(FifoDepth + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  state_e               r_state;
  logic [AddrWidth-1:0] r_base;
  logic [15:0]          r_len, r_issued, r_popped;
  logic [Latency-1:0]   r_vld_sr;
  logic [DataWidth-1:0] r_mem [FifoDepth];
  logic [PtrW-1:0]      r_wr, r_rd;
  logic [CntW-1:0]      r_count;
  logic                 r_done;
  logic [4:0]           w_inflight;
  logic                 w_req, w_push, w_pop, w_valid, w_last;
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < Latency; i++) w_inflight += 5'(r_vld_sr[i]);
  end
  // Reserve a FIFO slot for every outstanding read so the FIFO can never overflow.
  assign w_req   = (r_state == RUN) && (r_issued < r_len) &&
                   (32'(w_inflight) + 32'(r_count) < FifoDepth);
  assign w_push  = r_vld_sr[Latency-1];
  assign w_valid = r_count != '0;
  assign w_pop   = w_valid && ready_i;
  assign w_last  = w_valid && (r_popped == r_len - 16'd1);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_base   <= '0;
      r_len    <= '0;
      r_issued <= '0;
      r_popped <= '0;
      r_vld_sr <= '0;
      r_wr     <= '0;
      r_rd     <= '0;
      r_count  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_vld_sr <= Latency'({r_vld_sr, w_req});
      r_count  <= r_count + CntW'(w_push) - CntW'(w_pop);
      if (w_push) r_wr <= (r_wr == PtrW'(FifoDepth - 1)) ? '0 : r_wr + 1'b1;
      if (w_pop) r_rd <= (r_rd == PtrW'(FifoDepth - 1)) ? '0 : r_rd + 1'b1;
      if (w_pop) r_popped <= r_popped + 16'd1;
      if (w_req) r_issued <= r_issued + 16'd1;
      case (r_state)
        IDLE: if (start_i) begin
          r_base   <= base_addr_i;
          r_len    <= len_i;
          r_issued <= '0;
          r_popped <= '0;
          if (len_i != '0) r_state <= RUN;
          else r_done <= 1'b1;
        end
        RUN: if (w_req && r_issued == r_len - 16'd1) r_state <= DRAIN;
        DRAIN: if (w_pop && w_last) begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr] <= rdata_i;
  end
`ifdef SRAM_STREAM_READER_PERF_EN
  logic [31:0] r_stall;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_stall <= '0;
    else if (r_state == IDLE && start_i) r_stall <= '0;
    else if (w_valid && !ready_i && r_stall != '1) r_stall <= r_stall + 32'd1;
  end
  assign stall_cycles_o = r_stall;
`else
  assign stall_cycles_o = '0;
`endif
  assign busy_o  = r_state != IDLE;
  assign done_o  = r_done;
  assign req_o   = w_req;
  assign we_o    = 1'b0;
  assign wdata_o = '0;
  assign be_o    = '0;
  assign addr_o  = AddrWidth'((32'(r_base) + 32'(r_issued)) % NumWords);
  assign valid_o = w_valid;
  assign data_o  = w_valid ? r_mem[r_rd] : '0;
  assign last_o  = w_last;
endmodule

// File: tb/tb_sram_stream_reader.sv
// tb_sram_stream_reader: directed checks of sram_stream_reader against an SRAM holding word[i]=i.
module tb_sram_stream_reader;
  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        start_i = 1'b0, ready_i = 1'b0;
  logic [9:0]  base_addr_i = '0;
  logic [15:0] len_i = '0;
  logic        busy_o, done_o, req_o, we_o, valid_o, last_o;
  logic [9:0]  addr_o;
  logic [31:0] wdata_o, data_o, stall_cycles_o;
  logic [31:0] rdata_i = '0;
  logic [3:0]  be_o;
  int n_assert = 0, n_fail = 0;
  int mbase, mlen, n_req, n_pop;
  bit last_hs;

  sram_stream_reader #(.NumWords(1024), .DataWidth(32), .Latency(1), .FifoDepth(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .base_addr_i(base_addr_i),
    .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .req_o(req_o), .we_o(we_o),
    .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o), .rdata_i(rdata_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .last_o(last_o),
    .stall_cycles_o(stall_cycles_o));

  always #5 clk_i = ~clk_i;
  always_ff @(posedge clk_i) if (req_o) rdata_i <= 32'(addr_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called with the inputs that the coming posedge will sample.
  task automatic observe();
    if (req_o) begin
      chk("addr", 32'(addr_o), 32'((mbase + n_req) % 1024));
      n_req++;
    end
    if (valid_o && ready_i) begin
      chk("data", data_o, 32'((mbase + n_pop) % 1024));
      chk("last", 32'(last_o), 32'(n_pop == mlen - 1));
      if (last_o) last_hs = 1'b1;
      n_pop++;
    end
  endtask

  task automatic cyc();
    observe();
    @(negedge clk_i);
  endtask

  task automatic start_xfer(input int base, input int len);
    base_addr_i = 10'(base);
    len_i = 16'(len);
    start_i = 1'b1;
    mbase = base; mlen = len; n_req = 0; n_pop = 0; last_hs = 1'b0;
    cyc();
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (last_hs) begin ok = 1'b1; break; end
    end
    chk("done_timeout", 32'(ok), 1);
    chk("done_after_last", 32'(done_o), 1);
    chk("idle_after_last", 32'(busy_o), 0);
    chk("words", 32'(n_pop), 32'(mlen));
    chk("reqs", 32'(n_req), 32'(mlen));
    cyc();
    chk("done_one_cycle", 32'(done_o), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_done"}, 32'(done_o), 0);
    chk({tag, "_req"}, 32'(req_o), 0);
    chk({tag, "_valid"}, 32'(valid_o), 0);
    chk({tag, "_last"}, 32'(last_o), 0);
    chk({tag, "_addr"}, 32'(addr_o), 0);
    chk({tag, "_data"}, data_o, 0);
    chk({tag, "_stall"}, stall_cycles_o, 0);
  endtask

  initial begin
    int exp_stall;
    repeat (2) @(negedge clk_i);
    chk_zero("reset");
    chk("reset_we", 32'(we_o), 0);
    chk("reset_wdata", wdata_o, 0);
    chk("reset_be", 32'(be_o), 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Basic 8-word transfer with ready high; stray starts while busy are ignored.
    ready_i = 1'b1;
    start_xfer(16, 8);
    chk("busy_run", 32'(busy_o), 1);
    for (int i = 0; i < 8; i++) begin
      chk("req_consecutive", 32'(req_o), 1);
      start_i = (i == 3);
      base_addr_i = 10'h100;
      cyc();
    end
    start_i = 1'b0;
    chk("req_count8", 32'(n_req), 8);
    chk("req_stops", 32'(req_o), 0);
    wait_done();

    // Zero-length start.
    start_xfer(5, 0);
    chk("len0_done", 32'(done_o), 1);
    chk("len0_busy", 32'(busy_o), 0);
    chk("len0_req", 32'(req_o), 0);
    cyc();
    chk("len0_done_pulse", 32'(done_o), 0);
    chk("len0_busy2", 32'(busy_o), 0);
    chk("len0_reqs", 32'(n_req), 0);

    // Back-pressure: FIFO depth limits outstanding reads.
    ready_i = 1'b0;
    start_xfer(0, 8);
    repeat (10) cyc();
    chk("bp_reqs", 32'(n_req), 4);
    chk("bp_valid", 32'(valid_o), 1);
    chk("bp_data", data_o, 0);
    chk("bp_last", 32'(last_o), 0);
    chk("bp_req_off", 32'(req_o), 0);
    cyc();
    chk("bp_hold_valid", 32'(valid_o), 1);
    chk("bp_hold_data", data_o, 0);
    ready_i = 1'b1;
    wait_done();

    // Address wrap at the top of memory.
    start_xfer(10'h3FE, 4);
    wait_done();

    // Stall counter: 5 cycles of valid with ready low.
    ready_i = 1'b0;
    start_xfer(10'h40, 2);
    chk("stall_cleared", stall_cycles_o, 0);
    repeat (2) cyc();
    chk("stall_valid", 32'(valid_o), 1);
    repeat (5) cyc();
`ifdef SRAM_STREAM_READER_PERF_EN
    exp_stall = 5;
`else
    exp_stall = 0;
`endif
    chk("stall_count", stall_cycles_o, 32'(exp_stall));
    ready_i = 1'b1;
    wait_done();

    // Reset in the middle of a transfer.
    start_xfer(0, 8);
    for (int i = 0; i < 30 && n_pop < 3; i++) cyc();
    chk("hs3", 32'(n_pop), 3);
    rst_ni = 1'b0;
    #1;
    chk_zero("midreset");
    repeat (2) begin
      @(negedge clk_i);
      chk("midreset_nodone", 32'(done_o), 0);
      chk("midreset_valid", 32'(valid_o), 0);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post_reset_nodone", 32'(done_o), 0);
    start_xfer(10'h20, 2);
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
